// File: rtl/regfile_fwd_sb_pkg.sv
// Shared constants for the decode-stage register file:
// operand source select encoding.
package regfile_fwd_sb_pkg;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EX  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_DM  = 2'b10;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/rf_fwd_mux.sv
// Per-port operand mux: register latch or a forwarded result,
// optionally overridden by the immediate.
module rf_fwd_mux
    import regfile_fwd_sb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] reg_q,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic              imm_en,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] src;

    always_comb begin
        src = reg_q;
        unique case (sel)
            FWD_REG: src = reg_q;
            FWD_EX:  src = ans_ex;
            FWD_DM:  src = ans_dm;
            FWD_WB:  src = ans_wb;
            default: src = reg_q;
        endcase
    end

    assign dout = imm_en ? imm : src;

endmodule

// File: rtl/regfile_fwd_sb.sv
// Parametrised register file with write-through bypass,
// operand forwarding and a per-register busy scoreboard.
module regfile_fwd_sb
    import regfile_fwd_sb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD*SEL_W-1:0]    fwd_sel,
    input  logic [DATA_W-1:0]          ans_ex,
    input  logic [DATA_W-1:0]          ans_dm,
    input  logic [DATA_W-1:0]          ans_wb,
    input  logic [DATA_W-1:0]          imm,
    input  logic                       imm_sel,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          hazard
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem  [NREGS];
    logic [DATA_W-1:0] rd_q [NUM_RD];
    logic [NREGS-1:0]  busy;
    logic [NUM_RD-1:0] hazard_q;
    logic              wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Set after clear so a same-cycle issue marks the new producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_en) busy[wr_addr] <= 1'b0;
            if (iss_en) busy[iss_addr] <= 1'b1;
            if (ZERO_REG != 0) busy[0] <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [ADDR_W-1:0] ra;
        logic              bypass;
        logic              zero_rd;

        assign ra      = rd_addr[i*ADDR_W +: ADDR_W];
        assign bypass  = wr_ok && (wr_addr == ra);
        assign zero_rd = (ZERO_REG != 0) && (ra == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q[i]     <= '0;
                hazard_q[i] <= 1'b0;
            end else begin
                if (zero_rd) rd_q[i] <= '0;
                else if (bypass) rd_q[i] <= wr_data;
                else rd_q[i] <= mem[ra];
                hazard_q[i] <= busy[ra] && !(wr_en && wr_addr == ra);
            end
        end

        rf_fwd_mux #(
            .DATA_W (DATA_W)
        ) u_mux (
            .sel    (fwd_sel[i*SEL_W +: SEL_W]),
            .reg_q  (rd_q[i]),
            .ans_ex (ans_ex),
            .ans_dm (ans_dm),
            .ans_wb (ans_wb),
            .imm_en (imm_sel && (i == NUM_RD - 1)),
            .imm    (imm),
            .dout   (rd_data[i*DATA_W +: DATA_W])
        );
    end

    assign hazard = hazard_q;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed bench for regfile_fwd_sb with default parameters
// (8-bit data, 32 regs, 2 read ports, hardwired r0).
module tb_regfile_fwd_sb;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*2-1:0]      fwd_sel;
    logic [DATA_W-1:0]        ans_ex, ans_dm, ans_wb, imm;
    logic                     imm_sel;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        hazard;

    int checks = 0;
    int failures = 0;

    regfile_fwd_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .fwd_sel  (fwd_sel),
        .ans_ex   (ans_ex),
        .ans_dm   (ans_dm),
        .ans_wb   (ans_wb),
        .imm      (imm),
        .imm_sel  (imm_sel),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_data  (rd_data),
        .hazard   (hazard)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        iss_en  = 1'b0;
        fwd_sel = '0;
        imm_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        iss_addr = '0; ans_ex = '0; ans_dm = '0; ans_wb = '0; imm = '0;
        #3;
        checks++;
        if (rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=0000", rd_data);
        end
        checks++;
        if (hazard !== 2'b00) begin
            failures++;
            $display("FAIL reset_hazard got=%b exp=00", hazard);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'hA5;
        rd_addr = {5'd0, 5'd0};
        step();
        wr_en = 1'b0;
        rd_addr = {5'd7, 5'd7};
        step();
        checks++;
        if (rd_data[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL wr_rd_p0 got=%h exp=a5", rd_data[7:0]);
        end
        checks++;
        if (rd_data[15:8] !== 8'hA5) begin
            failures++;
            $display("FAIL wr_rd_p1 got=%h exp=a5", rd_data[15:8]);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h10;
        rd_addr = {5'd0, 5'd0};
        step();
        wr_data = 8'h3C;
        rd_addr = {5'd0, 5'd4};
        step();
        checks++;
        if (rd_data[7:0] !== 8'h3C) begin
            failures++;
            $display("FAIL bypass got=%h exp=3c", rd_data[7:0]);
        end
        wr_en = 1'b0;
        step();
        checks++;
        if (rd_data[7:0] !== 8'h3C) begin
            failures++;
            $display("FAIL bypass_after got=%h exp=3c", rd_data[7:0]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
        rd_addr = {5'd0, 5'd0};
        step();
        checks++;
        if (rd_data[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL zero_same_edge got=%h exp=00", rd_data[7:0]);
        end
        wr_en = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        checks++;
        if (rd_data[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL zero_later got=%h exp=00", rd_data[7:0]);
        end
        iss_en = 1'b0;
        step();
        checks++;
        if (hazard !== 2'b00) begin
            failures++;
            $display("FAIL zero_busy got=%b exp=00", hazard);
        end
    endtask

    task automatic test_fwd_imm();
        rd_addr = {5'd7, 5'd4};
        step();
        ans_ex = 8'h11; ans_dm = 8'h44; ans_wb = 8'h22; imm = 8'h33;
        fwd_sel = {2'b11, 2'b01};
        imm_sel = 1'b1;
        #1;
        checks++;
        if (rd_data !== 16'h3311) begin
            failures++;
            $display("FAIL fwd_imm got=%h exp=3311", rd_data);
        end
        imm_sel = 1'b0;
        #1;
        checks++;
        if (rd_data !== 16'h2211) begin
            failures++;
            $display("FAIL fwd_wb got=%h exp=2211", rd_data);
        end
        fwd_sel = {2'b00, 2'b10};
        #1;
        checks++;
        if (rd_data !== 16'hA544) begin
            failures++;
            $display("FAIL fwd_dm_reg got=%h exp=a544", rd_data);
        end
        fwd_sel = {2'b00, 2'b00};
        imm_sel = 1'b1;
        #1;
        checks++;
        if (rd_data !== 16'h333C) begin
            failures++;
            $display("FAIL imm_p1_only got=%h exp=333c", rd_data);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd0, 5'd9};
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        checks++;
        if (hazard !== 2'b00) begin
            failures++;
            $display("FAIL sb_iss_same_edge got=%b exp=00", hazard);
        end
        iss_en = 1'b0;
        rd_addr = {5'd9, 5'd9};
        step();
        checks++;
        if (hazard !== 2'b11) begin
            failures++;
            $display("FAIL sb_busy got=%b exp=11", hazard);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h55;
        step();
        checks++;
        if (hazard !== 2'b00) begin
            failures++;
            $display("FAIL sb_wr_resolve got=%b exp=00", hazard);
        end
        checks++;
        if (rd_data[7:0] !== 8'h55) begin
            failures++;
            $display("FAIL sb_wr_data got=%h exp=55", rd_data[7:0]);
        end
        wr_data = 8'h66;
        iss_en = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd0, 5'd0};
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        rd_addr = {5'd9, 5'd0};
        step();
        checks++;
        if (hazard !== 2'b10) begin
            failures++;
            $display("FAIL sb_set_wins got=%b exp=10", hazard);
        end
        checks++;
        if (rd_data[15:8] !== 8'h66) begin
            failures++;
            $display("FAIL sb_set_wins_data got=%h exp=66", rd_data[15:8]);
        end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h77;
        iss_en = 1'b1; iss_addr = 5'd2;
        rd_addr = {5'd0, 5'd0};
        step();
        idle();
        rd_addr = {5'd1, 5'd2};
        step();
        checks++;
        if (hazard !== 2'b01 || rd_data[15:8] !== 8'h77) begin
            failures++;
            $display("FAIL pre_reset got=%b/%h exp=01/77", hazard, rd_data[15:8]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (hazard !== 2'b00 || rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset got=%b/%h exp=00/0000", hazard, rd_data);
        end
        ans_ex = 8'h5A;
        fwd_sel = {2'b00, 2'b01};
        #1;
        checks++;
        if (rd_data !== 16'h005A) begin
            failures++;
            $display("FAIL reset_fwd got=%h exp=005a", rd_data);
        end
        fwd_sel = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        checks++;
        if (hazard !== 2'b00 || rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset got=%b/%h exp=00/0000", hazard, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_p1;
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1;
            wr_addr = 5'(10 + k);
            wr_data = 8'(8'h20 + k);
            rd_addr = {5'(9 + k), 5'(10 + k)};
            step();
            exp_p1 = (k == 0) ? 8'h00 : 8'(8'h20 + k - 1);
            checks++;
            if (rd_data[7:0] !== 8'(8'h20 + k) || rd_data[15:8] !== exp_p1) begin
                failures++;
                $display("FAIL b2b_%0d got=%h exp=%h%h", k, rd_data,
                         exp_p1, 8'(8'h20 + k));
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_fwd_imm();
        test_scoreboard();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_fwd_sb.md
# regfile_fwd_sb

Parametrised register file for the pipelined datapath, successor to the 8-bit, 32-entry, two-port bank. Adds configurable data width, depth and read-port count, asynchronous reset of all state, write enable, write-through bypass, an optional hardwired zero register, and a per-register busy scoreboard that flags read-after-write hazards. It sits in the decode stage: read addresses come from the fetched instruction, writes arrive from the DM/WB stage, and forwarded results (EX/DM/WB) plus an immediate are muxed onto the operand outputs.

## Interface
- DATA_W, 8, data width of every register and operand
- ADDR_W, 5, register address width; depth NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (>= 1)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- fwd_sel  in  NUM_RD*2  per-port operand source: 00 register, 01 ans_ex, 10 ans_dm, 11 ans_wb
- ans_ex / ans_dm / ans_wb  in  DATA_W each  forwarded results
- imm  in  DATA_W  immediate operand
- imm_sel  in  1  replaces port NUM_RD-1 output with imm
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- iss_en  in  1  marks iss_addr as having a result in flight
- iss_addr  in  ADDR_W  destination of the issued instruction
- rd_data  out  NUM_RD*DATA_W  packed operand outputs
- hazard  out  NUM_RD  per-port: addressed register was busy when read was latched

## Operation
- Storage: NREGS x DATA_W array; read latches rd_q[i] (DATA_W); busy[NREGS]; hazard_q[i].
- Write: on posedge, if wr_en and not (ZERO_REG and wr_addr==0), mem[wr_addr] <= wr_data.
- Read: every posedge, rd_q[i] <= mem[rd_addr[i]]; if wr_en and wr_addr==rd_addr[i] (and write not suppressed), rd_q[i] <= wr_data (write-through). Address 0 with ZERO_REG reads 0.
- Output mux (combinational): per port, fwd_sel selects rd_q[i]/ans_ex/ans_dm/ans_wb; port NUM_RD-1 then overridden by imm when imm_sel=1. imm_sel has no effect on other ports.
- Scoreboard: on posedge, write clears busy[wr_addr] when wr_en; issue sets busy[iss_addr] when iss_en. Same address both in one cycle: set wins (new producer). ZERO_REG: busy[0] stays 0.
- hazard_q[i] <= busy[rd_addr[i]] and not (wr_en and wr_addr==rd_addr[i]); i.e. a write in the same cycle resolves the hazard. Issue in the same cycle does not raise hazard for that read.
- hazard = hazard_q; advisory only, block never stalls itself.

## Timing
- Reset (rst=1, async): all mem, rd_q, busy, hazard_q cleared to 0. hazard=0; rd_data=0 when fwd_sel=00 and imm_sel=0, otherwise follows muxed inputs.
- rst deasserted mid-operation then reasserted: in-flight busy bits lost, no partial state retained.
- Read latency: 1 cycle from rd_addr to rd_q; fwd_sel/imm/ans_* to rd_data: 0 cycles (combinational).
- Write visible to a read latched on the same edge (bypass) and all later reads.
- Scoreboard set/clear effective for reads latched on the following edge.
- Out-of-range addresses impossible (NREGS = 2**ADDR_W).

## Structure
- Shared package: fwd_sel encoding constants (FWD_REG, FWD_EX, FWD_DM, FWD_WB) and select width 2.
- Sub-module rf_fwd_mux: one per read port (generate loop), 4:1 source mux plus optional imm override, parameter DATA_W.
- Top holds array, read latches, bypass compare and scoreboard.

## Test plan
- Reset: load mem via writes, assert rst mid-cycle -> all reads return 0x00, hazard=0 immediately.
- Write 0xA5 to r7, next cycle read r7 on port 0 with fwd_sel=00 -> rd_data[7:0]=0xA5 one cycle after address.
- Same-edge write 0x3C to r4 while reading r4 -> rd_q=0x3C (bypass), not old value.
- ZERO_REG=1: write 0xFF to r0, read r0 -> 0x00; iss_en to r0 -> hazard stays 0.
- Forward/imm: fwd_sel port0=01 (ans_ex=0x11), port1=11 (ans_wb=0x22), imm_sel=1 imm=0x33 -> port0=0x11, port1=0x33.
- Scoreboard: iss r9, read r9 next cycle -> hazard[0]=1; wr_en r9 with simultaneous read -> hazard 0; iss and write r9 same edge -> busy stays 1, next read hazard=1.
